// File: rtl/pc_ctrl.sv
// Fetch sequencer: owns the PC, drives the imem handshake, handles redirects/traps
// and holds fetched instructions for decode. Optional fetch timeout: PC_CTRL_TIMEOUT_EN.
module pc_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned MAX_WAIT     = 15
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        trap_valid,
  output logic [1:0]  trap_cause,
  output logic [31:0] trap_pc,
  output logic [31:0] curr_pc
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CAUSE_W = 2;
  localparam logic [CAUSE_W-1:0] CAUSE_NONE    = CAUSE_W'(0);
  localparam logic [CAUSE_W-1:0] CAUSE_MISALIGN = CAUSE_W'(1);
  localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT  = CAUSE_W'(2);

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("pc_ctrl: MAX_WAIT out of range 1..255");
  end

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    curr_pc_q, curr_pc_d;
  logic               busy_q, busy_d;
  logic               pend_valid_q, pend_valid_d;
  logic [XLEN-1:0]    pend_pc_q, pend_pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic [XLEN-1:0]    instr_q, instr_d;
  logic [XLEN-1:0]    instr_pc_q, instr_pc_d;
  logic               trap_valid_q, trap_valid_d;
  logic [CAUSE_W-1:0] trap_cause_q, trap_cause_d;
  logic [XLEN-1:0]    trap_pc_q, trap_pc_d;
  logic               timeout_c;
  logic               accept_c;
  logic               waiting_c;

  // Request holds while a fetch is in flight so addr/req stay stable until ready.
  assign imem_req  = (state_q == ST_FETCH) && (busy_q || !instr_valid_q || !stall);
  assign imem_addr = curr_pc_q;
  assign accept_c  = imem_req && imem_ready;
  assign waiting_c = imem_req && !imem_ready;

`ifdef PC_CTRL_TIMEOUT_EN
  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] wait_q;

  assign timeout_c = (state_q == ST_FETCH) && waiting_c && (wait_q == WAIT_LAST);

  // Counts consecutive unanswered request cycles; any other FETCH event clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q <= '0;
    end else if ((state_q == ST_FETCH) && waiting_c && !redirect_valid && !timeout_c) begin
      wait_q <= wait_q + WAIT_W'(1);
    end else begin
      wait_q <= '0;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    curr_pc_d     = curr_pc_q;
    busy_d        = busy_q;
    pend_valid_d  = pend_valid_q;
    pend_pc_d     = pend_pc_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    trap_valid_d  = 1'b0;
    trap_cause_d  = CAUSE_NONE;
    trap_pc_d     = trap_pc_q;

    unique case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (instr_valid_q && !stall) begin
          instr_valid_d = 1'b0;
        end

        if (redirect_valid) begin
          instr_valid_d = 1'b0;
          if (redirect_target[1:0] != 2'b00) begin
            state_d      = ST_TRAP;
            trap_valid_d = 1'b1;
            trap_cause_d = CAUSE_MISALIGN;
            trap_pc_d    = redirect_target;
            pend_valid_d = 1'b0;
            busy_d       = 1'b0;
          end else if (waiting_c) begin
            // Keep the in-flight address; retarget once the response drains.
            pend_valid_d = 1'b1;
            pend_pc_d    = redirect_target;
            busy_d       = 1'b1;
          end else begin
            curr_pc_d    = redirect_target;
            pend_valid_d = 1'b0;
            busy_d       = 1'b0;
          end
        end else if (accept_c) begin
          busy_d = 1'b0;
          if (pend_valid_q) begin
            curr_pc_d    = pend_pc_q;
            pend_valid_d = 1'b0;
          end else begin
            instr_d       = imem_rdata;
            instr_pc_d    = curr_pc_q;
            instr_valid_d = 1'b1;
            curr_pc_d     = curr_pc_q + XLEN'(4);
          end
        end else if (timeout_c) begin
          state_d       = ST_TRAP;
          trap_valid_d  = 1'b1;
          trap_cause_d  = CAUSE_TIMEOUT;
          trap_pc_d     = curr_pc_q;
          instr_valid_d = 1'b0;
          pend_valid_d  = 1'b0;
          busy_d        = 1'b0;
        end else if (imem_req) begin
          busy_d = 1'b1;
        end
      end

      ST_TRAP: begin
        state_d       = ST_FETCH;
        curr_pc_d     = TRAP_VECTOR;
        pend_valid_d  = 1'b0;
        busy_d        = 1'b0;
        instr_valid_d = 1'b0;
      end

      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RST;
      curr_pc_q     <= RESET_VECTOR;
      busy_q        <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_pc_q     <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      trap_valid_q  <= 1'b0;
      trap_cause_q  <= CAUSE_NONE;
      trap_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      curr_pc_q     <= curr_pc_d;
      busy_q        <= busy_d;
      pend_valid_q  <= pend_valid_d;
      pend_pc_q     <= pend_pc_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      trap_valid_q  <= trap_valid_d;
      trap_cause_q  <= trap_cause_d;
      trap_pc_q     <= trap_pc_d;
    end
  end

  assign curr_pc     = curr_pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign trap_valid  = trap_valid_q;
  assign trap_cause  = trap_cause_q;
  assign trap_pc     = trap_pc_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_pc_ctrl;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
  localparam int          MW = 15;
`ifdef PC_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [1:0]  trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] curr_pc;

  int n_checks = 0;
  int n_errors = 0;

  pc_ctrl #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .curr_pc(curr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase 0 = post-reset idle, 1 = fetching, 2 = trap pulse.
  int          m_ph;
  logic [31:0] m_pc, m_ins, m_ipc, m_pend, m_tpc;
  bit          m_iv, m_busy, m_has_pend, m_tv;
  logic [1:0]  m_tc;
  int          m_wait;

  task automatic model_reset();
    m_ph = 0; m_pc = RV; m_ins = '0; m_ipc = '0; m_pend = '0; m_tpc = '0;
    m_iv = 0; m_busy = 0; m_has_pend = 0; m_tv = 0; m_tc = 2'd0; m_wait = 0;
  endtask

  function automatic bit exp_req();
    return (m_ph == 1) && (m_busy || !m_iv || !stall);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("imem_req",    32'(imem_req),    32'(exp_req()));
    check_eq("imem_addr",   imem_addr,        m_pc);
    check_eq("curr_pc",     curr_pc,          m_pc);
    check_eq("instr_valid", 32'(instr_valid), 32'(m_iv));
    check_eq("instr",       instr,            m_ins);
    check_eq("instr_pc",    instr_pc,         m_ipc);
    check_eq("trap_valid",  32'(trap_valid),  32'(m_tv));
    check_eq("trap_cause",  32'(trap_cause),  32'(m_tc));
    check_eq("trap_pc",     trap_pc,          m_tpc);
  endtask

  task automatic enter_trap(input logic [1:0] cause, input logic [31:0] where);
    m_ph = 2; m_tv = 1; m_tc = cause; m_tpc = where;
    m_iv = 0; m_busy = 0; m_has_pend = 0; m_wait = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_step();
    bit req;
    req = exp_req();
    if (m_ph == 0) begin
      m_ph = 1;
    end else if (m_ph == 2) begin
      m_ph = 1; m_pc = TV; m_has_pend = 0; m_busy = 0; m_wait = 0;
      m_tv = 0; m_tc = 2'd0;
    end else begin
      m_tv = 0; m_tc = 2'd0;
      if (m_iv && !stall) m_iv = 0;
      if (redirect_valid) begin
        m_iv = 0; m_wait = 0;
        if (redirect_target[1:0] != 2'b00) enter_trap(2'd1, redirect_target);
        else if (req && !imem_ready) begin
          m_has_pend = 1; m_pend = redirect_target; m_busy = 1;
        end else begin
          m_pc = redirect_target; m_has_pend = 0; m_busy = 0;
        end
      end else if (req && imem_ready) begin
        m_busy = 0; m_wait = 0;
        if (m_has_pend) begin
          m_pc = m_pend; m_has_pend = 0;
        end else begin
          m_ins = imem_rdata; m_ipc = m_pc; m_iv = 1; m_pc = m_pc + 32'd4;
        end
      end else if (req) begin
        m_busy = 1;
        m_wait++;
        if (TO_EN && m_wait == MW) enter_trap(2'd2, m_pc);
      end else begin
        m_wait = 0;
      end
    end
  endtask

  task automatic cycle(input bit rdy, input bit stl, input bit rv, input logic [31:0] rt);
    @(negedge clk);
    imem_ready = rdy; stall = stl; redirect_valid = rv; redirect_target = rt;
    imem_rdata = $urandom;
    #1;
    check_all();
    model_step();
    @(posedge clk);
  endtask

  // Asynchronous reset between edges, then release on a later falling edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;
    imem_ready = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    #1;
    check_all();
    model_step();
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] rt;
    reset = 1'b1;
    imem_ready = 1'b0; imem_rdata = '0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    model_reset();
    #2 reset = 1'b0;
    #1 check_all();
    do_reset();

    // Streaming with ready tied high.
    repeat (8) cycle(1, 0, 0, 32'h0);
    // Decode stall holds the output register and suppresses new requests.
    repeat (3) cycle(1, 1, 0, 32'h0);
    repeat (3) cycle(1, 0, 0, 32'h0);
    // Redirect while the request is outstanding: response dropped, then fetch target.
    cycle(0, 0, 1, 32'h0000_0200);
    repeat (3) cycle(0, 0, 0, 32'h0);
    repeat (4) cycle(1, 0, 0, 32'h0);
    // Misaligned redirect traps to the trap vector.
    cycle(1, 0, 1, 32'h0000_0202);
    repeat (4) cycle(1, 0, 0, 32'h0);
    // Memory never answers: timeout trap when enabled, indefinite wait otherwise.
    repeat (110) cycle(0, 0, 0, 32'h0);
    repeat (3) cycle(1, 0, 0, 32'h0);
    // PC wrap at the top of the address space.
    cycle(1, 0, 1, 32'hFFFF_FFFC);
    repeat (4) cycle(1, 0, 0, 32'h0);
    // Reset while a request is in flight.
    cycle(0, 0, 0, 32'h0);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      rt = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 9) == 0) rt = 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) rt = rt | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 799) == 0) do_reset();
      else cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 99) < 8, rt);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Fetch sequencer for the single-cycle core. It owns the program counter register and drives the instruction-memory request handshake. It applies branch/jump redirects, raising a trap on misaligned targets or stalled fetches, and presents fetched instructions to decode through a one-entry output register with a stall hold.

## Interface
- `RESET_VECTOR`, 32'h0000_0000, first fetch address after reset
- `TRAP_VECTOR`, 32'h0000_0100, fetch address after any trap
- `MAX_WAIT`, 15, cycles `imem_req` may stay unanswered before a timeout trap (range 1–255)

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low (0 = reset asserted)
- `imem_req` out 1: fetch request
- `imem_addr` out 32: fetch address, equal to `curr_pc`
- `imem_ready` in 1: memory returns `imem_rdata` this cycle
- `imem_rdata` in 32: fetched word
- `instr_valid` out 1: `instr`/`instr_pc` hold a valid instruction
- `instr` out 32: fetched instruction
- `instr_pc` out 32: address of `instr`
- `stall` in 1: decode not accepting; consume happens on `instr_valid && !stall`
- `redirect_valid` in 1: single-cycle redirect pulse
- `redirect_target` in 32: new PC
- `trap_valid` out 1: one-cycle trap pulse
- `trap_cause` out 2: 1 = misaligned redirect, 2 = fetch timeout, 0 = none
- `trap_pc` out 32: offending target or fetch address
- `curr_pc` out 32: PC being fetched

## Operation
- States: RST, FETCH, TRAP.
- Reset values: state RST, `curr_pc` = RESET_VECTOR, pending-redirect flag 0, wait counter 0, all other outputs 0.
- RST: one idle cycle with `imem_req` = 0, then go to FETCH.
- FETCH: `imem_req` = `!instr_valid || !stall`.
- Once raised, `imem_req` and `imem_addr` stay stable until `imem_ready`, even if `stall` rises.
- On `imem_ready` (no pending redirect):
  - `instr` <= `imem_rdata`
  - `instr_pc` <= `curr_pc`
  - `instr_valid` <= 1
  - `curr_pc` <= `curr_pc` + 4, mod 2^32 (0xFFFF_FFFC wraps to 0)
- A consume with no new ready clears `instr_valid`.
- Redirect has priority over all other FETCH events:
  - `instr_valid` <= 0 (flush).
  - If a request is outstanding (`imem_req && !imem_ready`), latch the target in the pending register and keep the address stable. When `imem_ready` arrives, discard the data and load `curr_pc` from the pending register.
  - Otherwise load `curr_pc` directly. Same-cycle `imem_ready` data is discarded.
  - A newer redirect overwrites an older pending redirect.
  - If `redirect_target[1:0]` != 0, go to TRAP with cause 1 and `trap_pc` = target. The pending register is cleared and any outstanding request is abandoned.
- Wait counter: increments each cycle `imem_req && !imem_ready`, clears on ready or redirect. Reaching MAX_WAIT goes to TRAP with cause 2 and `trap_pc` = `curr_pc`; `imem_req` drops.
- TRAP, one cycle:
  - `trap_valid` = 1, `imem_req` = 0, `instr_valid` = 0.
  - `curr_pc` <= TRAP_VECTOR, pending register cleared, then go to FETCH.
  - Redirects during TRAP are ignored.
- `trap_valid` and `trap_cause` return to 0 after the pulse; `trap_pc` holds its last value.
- Asserting `reset` mid-fetch immediately forces reset values. Any in-flight response is ignored.

## Timing
- `imem_addr` and `imem_req` are combinational from registered state and `stall`/`instr_valid` only; there is no path from `imem_ready` to `imem_req`.
- Fetch latency: `instr_valid` rises the cycle after `imem_ready`.
- Throughput: with `imem_ready` tied high and `stall` low, one instruction per cycle. Fetched addresses are RESET_VECTOR, +4, +8, …
- Redirect to first fetch at the target:
  - next cycle if no request is outstanding;
  - the cycle after the outstanding `imem_ready` otherwise.
- First `imem_req` after reset release: the second rising edge after `reset` returns to 1.
- Trap: `trap_valid` is high the cycle after the detecting edge; fetch at TRAP_VECTOR starts the following cycle.

## Configuration
- `PC_CTRL_TIMEOUT_EN` defined: wait counter and cause-2 trap are present.
- Not defined: no counter is synthesised, `imem_req` waits indefinitely, and `trap_cause` is only ever 0 or 1.

## Test plan
- Reset release, `imem_ready` = 1, `stall` = 0 → fetch addresses 0x0, 0x4, 0x8; `instr_pc` tracks them one cycle later; `instr_valid` stays high continuously.
- `stall` high for 3 cycles with `instr_valid` = 1 → `instr`/`instr_pc` unchanged and no new `imem_req`; the next address is fetched after `stall` falls.
- Redirect to 0x200 while `imem_ready` is held low for 4 cycles → `imem_addr` stays at the old PC until ready; that data is dropped; the next `imem_req` uses 0x200.
- Redirect to 0x202 → `trap_valid` pulse with cause 1 and `trap_pc` 0x202; then a fetch at 0x100.
- With `PC_CTRL_TIMEOUT_EN` and MAX_WAIT = 15, hold `imem_ready` low → cause-2 trap with `trap_pc` = `curr_pc`; then a fetch at 0x100. Without the macro there is no trap after 100 cycles.
- `curr_pc` = 0xFFFF_FFFC with ready → next `imem_addr` = 0x0; `reset` asserted mid-request → `imem_req` = 0 and `curr_pc` = RESET_VECTOR immediately.
